fma16_sched: RTL and testbench
==============================

# fma16_sched

Round-robin issue scheduler that shares one combinational `fma16` unit among `NREQ` requesters. Each requester posts an opcode and operands with a valid/ready handshake. The scheduler decodes the opcode into `fma16` control bits (`mul`, `add`, `negr`, `negz`) and holds registered operands on the unit for one execute cycle. It then returns the captured result and flags, tagged with the requester id, on a single back-pressured response port.

## Interface
- `NREQ`, default 4: number of requesters, minimum 2; `IDW = $clog2(NREQ)`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  one-hot grant / accept.
- `req_op`  in  3*NREQ  opcode per requester (slice i = bits [3i+2:3i]).
- `req_x`, `req_y`, `req_z`  in  16*NREQ  half-precision operands per requester.
- `req_rm`  in  2*NREQ  rounding mode per requester.
- `fma_x`, `fma_y`, `fma_z`  out  16  operands driven to `fma16`.
- `fma_mul`, `fma_add`, `fma_negr`, `fma_negz`  out  1  `fma16` controls.
- `fma_rm`  out  2  rounding mode to `fma16`.
- `fma_result`  in  16, `fma_flags`  in  4  outputs of `fma16`.
- `rsp_valid`  out  1, `rsp_ready`  in  1  response handshake.
- `rsp_id`  out  IDW, `rsp_result`  out  16, `rsp_flags`  out  4  response payload.
- `sticky_flags`  out  4*NREQ  present only with `FMA16_SCHED_STICKY_EN`.

## Operation
- Opcodes: 0 fmul, 1 fadd, 2 fsub, 3 fmadd, 4 fmsub, 5 fnmadd, 6 fnmsub, 7 reserved.
- Decode to {mul, add, negr, negz}:
  - fmul 1000, fadd 0100, fsub 0101
  - fmadd 1100, fmsub 1101, fnmadd 1110, fnmsub 1111
- FSM states:
  - IDLE: if any `req_valid`, grant one requester g. Assert `req_ready[g]`, latch op/x/y/z/rm and id g, update pointer to g, go to EXEC. Otherwise stay in IDLE.
  - EXEC: operand registers drive `fma_*`. Capture `fma_result`/`fma_flags` into the response registers at the clock edge, then go to RESP.
  - RESP: `rsp_valid`=1 and the payload is held stable until `rsp_ready`. On the handshake, if any `req_valid`, re-arbitrate in the same cycle and go to EXEC (back-to-back); otherwise go to IDLE.
- Arbitration: round-robin. Search starts at pointer+1 modulo NREQ; the pointer holds the last grant. `req_ready` is combinational from `req_valid` and is asserted only in IDLE, or in RESP while `rsp_ready`=1.
- Reserved opcode 7: accepted normally. EXEC drives all `fma_*` controls to 0. Response is `rsp_result`=16'h7E00 and `rsp_flags`=4'b1000 (invalid), regardless of `fma_result`.
- The requester may change `req_valid` at any time before its grant. Operands are sampled only in the grant cycle.
- Any non-EXEC state drives `fma_*` from the last latched values. No X is ever driven.

## Timing
- Reset values:
  - state IDLE; pointer NREQ-1, so requester 0 wins first.
  - `req_ready` 0 (no grant can occur while `reset` is high).
  - `rsp_valid` 0; `rsp_id`, `rsp_result`, `rsp_flags` 0.
  - all `fma_*` 0; `sticky_flags` 0.
- Latency: grant at cycle t, EXEC at t+1, `rsp_valid` at t+2.
- Throughput: one operation per 2 cycles with `rsp_ready` tied high.
- Back-pressure: RESP holds indefinitely. No new grant occurs while `rsp_valid`=1 and `rsp_ready`=0.
- `reset` asserted mid-operation: the in-flight operation is discarded, no response is emitted, and all state returns to reset values asynchronously.
- Single requester held valid continuously: granted every 2 cycles.

## Configuration
- `FMA16_SCHED_STICKY_EN` defined:
  - Per-requester 4-bit sticky register, OR-accumulated with `rsp_flags` into `sticky_flags[4*rsp_id +: 4]` on each response handshake.
  - Cleared only by reset.
- Undefined: the `sticky_flags` port and its registers are absent. No other behaviour changes.

## Structure
- Package `fma16_sched_pkg`:
  - `op_t` opcode enum and `state_t` FSM enum.
  - `fma_ctrl_t` packed struct {mul, add, negr, negz}.
  - `decode_op` function.
  - `QNAN16` = 16'h7E00 and `FLAG_NV` = 4'b1000 constants.
- Sub-module `rr_arbiter` (`NREQ` parameter): inputs are the request vector, the pointer and an enable; outputs are a one-hot grant and its encoded index. It is the only natural split.

## Test plan
- Reset, then requester 0 sends fmul with x=16'h3C00, y=16'h4000 -> `fma_mul`=1, `fma_add`=0 during EXEC; `rsp_valid` at t+2 with `rsp_id`=0 and `rsp_result`=16'h4000.
- All four requesters valid continuously with `rsp_ready`=1 -> grants go 0,1,2,3,0 on every second cycle; `rsp_id` follows the same sequence.
- Hold `rsp_ready`=0 for 5 cycles -> `rsp_valid` and payload stay stable and all `req_ready`=0; on release, the next grant occurs in the handshake cycle.
- Requester 2 sends opcode 7 -> `rsp_result`=16'h7E00, `rsp_flags`=4'b1000, and `fma_*` controls are 0 during EXEC.
- fnmsub from requester 1 -> EXEC controls 1111; assert `reset` during EXEC -> no `rsp_valid`, and all outputs return to 0 immediately.
- With `FMA16_SCHED_STICKY_EN`, two responses to id 3 with flags 4'b0001 then 4'b1000 -> `sticky_flags[15:12]`=4'b1001.

Source files
------------

// File: rtl/fma16_sched_pkg.sv
// Shared types, opcode decode and constants for the fma16 issue scheduler.
package fma16_sched_pkg;

  typedef enum logic [2:0] {
    OP_FMUL   = 3'd0,
    OP_FADD   = 3'd1,
    OP_FSUB   = 3'd2,
    OP_FMADD  = 3'd3,
    OP_FMSUB  = 3'd4,
    OP_FNMADD = 3'd5,
    OP_FNMSUB = 3'd6,
    OP_RSVD   = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic mul;
    logic add;
    logic negr;
    logic negz;
  } fma_ctrl_t;

  localparam logic [15:0] QNAN16  = 16'h7E00;
  localparam logic [3:0]  FLAG_NV = 4'b1000;

  // Reserved opcode decodes to all-zero controls; its result is substituted later.
  function automatic fma_ctrl_t decode_op(input op_t op);
    case (op)
      OP_FMUL:   decode_op = 4'b1000;
      OP_FADD:   decode_op = 4'b0100;
      OP_FSUB:   decode_op = 4'b0101;
      OP_FMADD:  decode_op = 4'b1100;
      OP_FMSUB:  decode_op = 4'b1101;
      OP_FNMADD: decode_op = 4'b1110;
      OP_FNMSUB: decode_op = 4'b1111;
      default:   decode_op = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/fma16_sched_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant, wrapping modulo NREQ.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic found;
  int   idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/fma16_sched.sv
// Shares one combinational fma16 among NREQ requesters (grant -> execute -> respond).
// Optional per-requester sticky flag accumulation: define FMA16_SCHED_STICKY_EN.
module fma16_sched
  import fma16_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [3*NREQ-1:0]    req_op,
  input  logic [16*NREQ-1:0]   req_x,
  input  logic [16*NREQ-1:0]   req_y,
  input  logic [16*NREQ-1:0]   req_z,
  input  logic [2*NREQ-1:0]    req_rm,
  output logic [15:0]          fma_x,
  output logic [15:0]          fma_y,
  output logic [15:0]          fma_z,
  output logic                 fma_mul,
  output logic                 fma_add,
  output logic                 fma_negr,
  output logic                 fma_negz,
  output logic [1:0]           fma_rm,
  input  logic [15:0]          fma_result,
  input  logic [3:0]           fma_flags,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_result,
  output logic [3:0]           rsp_flags
`ifdef FMA16_SCHED_STICKY_EN
  ,
  output logic [4*NREQ-1:0]    sticky_flags
`endif
);

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, id_q, gnt_id;
  logic [NREQ-1:0] gnt;
  logic           arb_en;
  fma_ctrl_t      ctrl_q;
  logic           rsvd_q;
  logic [15:0]    x_q, y_q, z_q;
  logic [1:0]     rm_q;
  logic [2:0]     sel_op;
  logic [15:0]    sel_x, sel_y, sel_z;
  logic [1:0]     sel_rm;

  // Grants are possible only when the operand registers are free for the next cycle.
  assign arb_en = !reset && ((state_q == S_IDLE) || (state_q == S_RESP && rsp_ready));

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = gnt;

  always_comb begin
    sel_op = '0;
    sel_x  = '0;
    sel_y  = '0;
    sel_z  = '0;
    sel_rm = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_op = req_op[3*i +: 3];
        sel_x  = req_x[16*i +: 16];
        sel_y  = req_y[16*i +: 16];
        sel_z  = req_z[16*i +: 16];
        sel_rm = req_rm[2*i +: 2];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|gnt) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = (|gnt) ? S_EXEC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: operand and payload registers are reset too, so the fma16 inputs and response port never carry X.
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= IDW'(NREQ - 1);
      id_q       <= '0;
      ctrl_q     <= '0;
      rsvd_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      rm_q       <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      state_q <= state_d;
      if (|gnt) begin
        ptr_q  <= gnt_id;
        id_q   <= gnt_id;
        ctrl_q <= decode_op(op_t'(sel_op));
        rsvd_q <= (sel_op == OP_RSVD);
        x_q    <= sel_x;
        y_q    <= sel_y;
        z_q    <= sel_z;
        rm_q   <= sel_rm;
      end
      if (state_q == S_EXEC) begin
        rsp_id     <= id_q;
        rsp_result <= rsvd_q ? QNAN16 : fma_result;
        rsp_flags  <= rsvd_q ? FLAG_NV : fma_flags;
      end
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign fma_x     = x_q;
  assign fma_y     = y_q;
  assign fma_z     = z_q;
  assign fma_rm    = rm_q;
  assign fma_mul   = ctrl_q.mul;
  assign fma_add   = ctrl_q.add;
  assign fma_negr  = ctrl_q.negr;
  assign fma_negz  = ctrl_q.negz;

`ifdef FMA16_SCHED_STICKY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_flags <= '0;
    end else if (rsp_valid && rsp_ready) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_id == IDW'(i)) sticky_flags[4*i +: 4] <= sticky_flags[4*i +: 4] | rsp_flags;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fma16_sched.sv
// Self-checking bench for fma16_sched: vector table, scoreboard, and hand-written corner sequences.
module tb_fma16_sched;
  import fma16_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid, req_ready;
  logic [3*NREQ-1:0]   req_op;
  logic [16*NREQ-1:0]  req_x, req_y, req_z;
  logic [2*NREQ-1:0]   req_rm;
  logic [15:0]         fma_x, fma_y, fma_z, fma_result;
  logic                fma_mul, fma_add, fma_negr, fma_negz;
  logic [1:0]          fma_rm;
  logic [3:0]          fma_flags;
  logic                rsp_valid, rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [15:0]         rsp_result;
  logic [3:0]          rsp_flags;
`ifdef FMA16_SCHED_STICKY_EN
  logic [4*NREQ-1:0]   sticky_flags;
`endif

  always #5 clk = ~clk;

  fma16_sched #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_z      (req_z),
    .req_rm     (req_rm),
    .fma_x      (fma_x),
    .fma_y      (fma_y),
    .fma_z      (fma_z),
    .fma_mul    (fma_mul),
    .fma_add    (fma_add),
    .fma_negr   (fma_negr),
    .fma_negz   (fma_negz),
    .fma_rm     (fma_rm),
    .fma_result (fma_result),
    .fma_flags  (fma_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags)
`ifdef FMA16_SCHED_STICKY_EN
    ,
    .sticky_flags (sticky_flags)
`endif
  );

  // Stand-in for the fma16 unit: exact for 1.0*y, otherwise a control-sensitive scramble.
  function automatic logic [15:0] fake_fma(input logic [15:0] x, input logic [15:0] y,
                                           input logic [15:0] z, input logic [3:0] c,
                                           input logic [1:0] rm);
    if (c == 4'b1000 && x == 16'h3C00) return y;
    return (x ^ {y[7:0], y[15:8]}) + z + {c, rm, 10'h000};
  endfunction

  always_comb begin
    fma_result = fake_fma(fma_x, fma_y, fma_z, {fma_mul, fma_add, fma_negr, fma_negz}, fma_rm);
    fma_flags  = fma_z[3:0];
  end

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [15:0]    res;
    logic [3:0]     flags;
  } exp_t;

  typedef struct {
    int          id;
    logic [2:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [1:0]  rm;
    logic [3:0]  ctrl;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[8];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t make_exp(input int id, input logic [2:0] op, input logic [15:0] x,
                                    input logic [15:0] y, input logic [15:0] z,
                                    input logic [1:0] rm, input logic [3:0] ctrl);
    exp_t e;
    e.id    = IDW'(id);
    e.res   = (op == 3'd7) ? 16'h7E00 : fake_fma(x, y, z, ctrl, rm);
    e.flags = (op == 3'd7) ? 4'b1000 : z[3:0];
    return e;
  endfunction

  task automatic set_req(input int id, input logic [2:0] op, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] z, input logic [1:0] rm);
    req_op[3*id +: 3]  = op;
    req_x[16*id +: 16] = x;
    req_y[16*id +: 16] = y;
    req_z[16*id +: 16] = z;
    req_rm[2*id +: 2]  = rm;
  endtask

  function automatic logic [3:0] ctrl_now();
    return {fma_mul, fma_add, fma_negr, fma_negz};
  endfunction

  // One isolated transaction; entered and left in IDLE, one step after a rising edge.
  task automatic do_op(input vec_t v);
    set_req(v.id, v.op, v.x, v.y, v.z, v.rm);
    req_valid       = '0;
    req_valid[v.id] = 1'b1;
    #1;
    check("grant", req_ready, 32'(1) << v.id);
    sb.push_back(make_exp(v.id, v.op, v.x, v.y, v.z, v.rm, v.ctrl));
    @(posedge clk); #1;
    req_valid = '0;
    check("exec_ctrl", ctrl_now(), v.ctrl);
    check("exec_x", fma_x, v.x);
    check("exec_y", fma_y, v.y);
    check("exec_z", fma_z, v.z);
    check("exec_rm", fma_rm, v.rm);
    check("exec_no_rsp", rsp_valid, 0);
    @(posedge clk); #1;
    check("rsp_latency", rsp_valid, 1);
    @(posedge clk); #1;
  endtask

  // Scoreboard: every response handshake pops and compares one expected record.
  always @(negedge clk) begin
    if (reset === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL rsp_unexpected: got response id %0d, want none", rsp_id);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_id", rsp_id, mon_e.id);
        check("rsp_result", rsp_result, mon_e.res);
        check("rsp_flags", rsp_flags, mon_e.flags);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, want finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{0, 3'd0, 16'h3C00, 16'h4000, 16'h0000, 2'd0, 4'b1000};
    vecs[1] = '{1, 3'd1, 16'h4248, 16'h3800, 16'h0002, 2'd1, 4'b0100};
    vecs[2] = '{3, 3'd2, 16'hC000, 16'h3C00, 16'h0003, 2'd2, 4'b0101};
    vecs[3] = '{0, 3'd3, 16'h3555, 16'h4100, 16'h4400, 2'd3, 4'b1100};
    vecs[4] = '{1, 3'd4, 16'h1234, 16'h5678, 16'h9ABC, 2'd0, 4'b1101};
    vecs[5] = '{2, 3'd5, 16'hBC00, 16'h4200, 16'h0005, 2'd1, 4'b1110};
    vecs[6] = '{3, 3'd6, 16'h7BFF, 16'h0001, 16'h8000, 2'd2, 4'b1111};
    vecs[7] = '{2, 3'd7, 16'h3C00, 16'h3C00, 16'h3C00, 2'd0, 4'b0000};

    // Reset state, with every requester asking to be served.
    reset     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '1;
    req_op    = '0;
    req_x     = '0;
    req_y     = '0;
    req_z     = '0;
    req_rm    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_payload", {rsp_id, rsp_result, rsp_flags}, 0);
    check("rst_fma_ops", {fma_x, fma_y, fma_z}, 0);
    check("rst_fma_ctrl", {ctrl_now(), fma_rm}, 0);
`ifdef FMA16_SCHED_STICKY_EN
    check("rst_sticky", sticky_flags, 0);
`endif
    req_valid = '0;
    reset     = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) do_op(vecs[v]);

    // All requesters valid continuously: grants 0,1,2,3,0 every second cycle.
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++)
      set_req(i, 3'd1, 16'h1000 + 16'(i), 16'h0100 * 16'(i + 1), 16'(i + 8), 2'(i));
    req_valid = '1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (k % 2 == 0) begin
        check("rr_grant", req_ready, 32'(1) << ((k / 2) % NREQ));
        sb.push_back(make_exp((k / 2) % NREQ, 3'd1, 16'h1000 + 16'((k / 2) % NREQ),
                              16'h0100 * 16'((k / 2) % NREQ + 1), 16'((k / 2) % NREQ + 8),
                              2'((k / 2) % NREQ), 4'b0100));
      end else begin
        check("rr_gap", req_ready, 0);
      end
      if (k == 9) req_valid = '0;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Back-pressure: response from requester 1 held while requester 3 waits.
    rsp_ready = 1'b0;
    set_req(1, 3'd3, 16'h4400, 16'h3E00, 16'h000C, 2'd1);
    set_req(3, 3'd0, 16'h3C00, 16'h4500, 16'h0001, 2'd0);
    req_valid = 4'b0010;
    #1;
    check("bp_grant1", req_ready, 4'b0010);
    mon_e = make_exp(1, 3'd3, 16'h4400, 16'h3E00, 16'h000C, 2'd1, 4'b1100);
    sb.push_back(mon_e);
    @(posedge clk); #1;
    req_valid = 4'b1000;
    check("bp_exec_no_grant", req_ready, 0);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_payload", {rsp_id, rsp_result, rsp_flags}, {mon_e.id, mon_e.res, mon_e.flags});
      check("bp_hold_no_grant", req_ready, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_grant", req_ready, 4'b1000);
    sb.push_back(make_exp(3, 3'd0, 16'h3C00, 16'h4500, 16'h0001, 2'd0, 4'b1000));
    @(posedge clk); #1;
    req_valid = '0;
    check("bp_b2b_exec", ctrl_now(), 4'b1000);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // fnmsub from requester 1, reset during EXEC discards it.
    set_req(1, 3'd6, 16'h4000, 16'h4000, 16'h4000, 2'd3);
    req_valid = 4'b0010;
    #1;
    check("rst_mid_grant", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    check("rst_mid_exec_ctrl", ctrl_now(), 4'b1111);
    #2;
    reset     = 1'b1;
    req_valid = '1;
    #1;
    check("rst_mid_ctrl_zero", {ctrl_now(), fma_rm}, 0);
    check("rst_mid_ops_zero", {fma_x, fma_y, fma_z}, 0);
    check("rst_mid_no_rsp", rsp_valid, 0);
    check("rst_mid_no_grant", req_ready, 0);
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_mid_hold", rsp_valid, 0);
    end
    req_valid = '0;
    reset     = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_mid_after", rsp_valid, 0);
    end

`ifdef FMA16_SCHED_STICKY_EN
    do_op('{3, 3'd0, 16'h1111, 16'h2222, 16'h0001, 2'd0, 4'b1000});
    do_op('{3, 3'd7, 16'h0000, 16'h0000, 16'h0000, 2'd0, 4'b0000});
    check("sticky_id3", sticky_flags[15:12], 4'b1001);
    check("sticky_others", sticky_flags[11:0], 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
